// File: rtl/regfile_port_ctrl_if.sv
// regfile_port_ctrl_if: writeback, debug, clear-command and register-file write bus
interface regfile_port_ctrl_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          clr_start;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          dbg_ack;
    logic          busy;
    logic          stall_req;
    logic          wb_drop;

    modport slave (
        input  wb_we, wb_addr, wb_data, dbg_req, dbg_addr, dbg_data, clr_start,
        output rf_we, rf_addr, rf_data, dbg_ack, busy, stall_req, wb_drop
    );

    modport master (
        output wb_we, wb_addr, wb_data, dbg_req, dbg_addr, dbg_data, clr_start,
        input  rf_we, rf_addr, rf_data, dbg_ack, busy, stall_req, wb_drop
    );
endinterface

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: shares the register-file write port between writeback and debug, and zeroes the file
module regfile_port_ctrl #(
    parameter int NREG         = 32,
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int STARVE_MAX   = 8,
    parameter int CLR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_port_ctrl_if.slave  bus
);
    typedef enum logic {CLEAR, IDLE} state_t;

    localparam state_t        RST_STATE = (CLR_ON_RESET != 0) ? CLEAR : IDLE;
    localparam logic [AW:0]   LAST      = (AW+1)'(NREG - 1);
    localparam logic [4:0]    SMAX      = 5'(STARVE_MAX);

    state_t        state_q, state_d;
    logic [AW:0]   clr_cnt_q, clr_cnt_d;
    logic [3:0]    starve_cnt_q, starve_cnt_d;
    logic          stall_q, stall_d;
    logic          grant, blocked, we_c, ack_c, drop_c;
    logic [4:0]    starve_inc;

    // Port arbitration and output muxing; enables are gated off while in reset
    always_comb begin
        grant       = 1'b0;
        we_c        = 1'b0;
        ack_c       = 1'b0;
        drop_c      = 1'b0;
        bus.rf_addr = bus.wb_addr;
        bus.rf_data = bus.wb_data;
        bus.busy    = 1'b0;
        if (state_q == CLEAR) begin
            we_c        = 1'b1;
            drop_c      = bus.wb_we;
            bus.rf_addr = clr_cnt_q[AW-1:0];
            bus.rf_data = '0;
            bus.busy    = 1'b1;
        end else begin
            grant       = bus.dbg_req && (stall_q || !bus.wb_we);
            we_c        = grant || bus.wb_we;
            ack_c       = grant;
            drop_c      = grant && bus.wb_we;
            bus.rf_addr = grant ? bus.dbg_addr : bus.wb_addr;
            bus.rf_data = grant ? bus.dbg_data : bus.wb_data;
        end
        bus.rf_we     = rst_n && we_c;
        bus.dbg_ack   = rst_n && ack_c;
        bus.wb_drop   = rst_n && drop_c;
        bus.stall_req = stall_q;
    end

    // Clear sequencing, starvation tracking and clear-command handling
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        starve_cnt_d = starve_cnt_q;
        stall_d      = stall_q;
        blocked      = bus.dbg_req && !grant;
        starve_inc   = {1'b0, starve_cnt_q} + 5'd1;
        if (state_q == CLEAR) begin
            state_d   = (clr_cnt_q == LAST) ? IDLE : CLEAR;
            clr_cnt_d = (clr_cnt_q == LAST) ? '0 : clr_cnt_q + 1'b1;
        end else if (bus.clr_start) begin
            state_d      = CLEAR;
            clr_cnt_d    = '0;
            starve_cnt_d = '0;
            stall_d      = 1'b0;
        end else begin
            starve_cnt_d = !blocked ? 4'd0 : (starve_cnt_q == 4'd15) ? 4'd15 : starve_inc[3:0];
            stall_d      = grant ? 1'b0 : (blocked && starve_inc == SMAX) ? 1'b1 : stall_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_STATE;
            clr_cnt_q    <= '0;
            starve_cnt_q <= '0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            stall_q      <= stall_d;
        end
    end
endmodule
